// File: rtl/spart_tx_fifo_if.sv
// spart_tx_fifo_if: processor-side write bus of the SPART transmitter.
// Word push plus buffer status returned to the processor.
interface spart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                              write;
  logic [DATA_W-1:0]                 tx_in;
  logic                              tbr;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              overflow;

  modport master (
    output write, tx_in,
    input  tbr, fifo_count, overflow
  );

  modport slave (
    input  write, tx_in,
    output tbr, fifo_count, overflow
  );
endinterface

// File: rtl/spart_tx_fifo.sv
// spart_tx_fifo: buffered SPART serial transmitter.
// Queued words go out LSB-first as start/data/[parity]/stop per baud tick.
module spart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_enable,
  spart_tx_fifo_if.slave     bus,
  output logic               txd,
  output logic               tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(DATA_W+1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              push, pop;
  logic              ovf;

  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [BW-1:0]     bidx, bidx_n;
  logic              scnt, scnt_n;
  logic              par, par_n;
  logic              txd_n;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = bus.write && !full;

  assign bus.tbr        = !full;
  assign bus.fifo_count = count;
  assign bus.overflow   = ovf;
  assign tx_busy        = (state != IDLE);

  // FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.tx_in;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bus.write && full)
        ovf <= 1'b1;
    end
  end

  // frame FSM and line driver registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      bidx  <= '0;
      scnt  <= 1'b0;
      par   <= 1'b0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      bidx  <= bidx_n;
      scnt  <= scnt_n;
      par   <= par_n;
      txd   <= txd_n;
    end
  end

  // next-state: advance only on baud ticks, chain frames from STOP
  always_comb begin
    state_n = state;
    sh_n    = sh;
    bidx_n  = bidx;
    scnt_n  = scnt;
    par_n   = par;
    txd_n   = txd;
    pop     = 1'b0;
    if (tx_enable) begin
      unique case (state)
        IDLE: begin
          pop = !empty;
        end
        START: begin
          txd_n   = sh[0];
          sh_n    = sh >> 1;
          bidx_n  = BW'(1);
          state_n = DATA;
        end
        DATA: begin
          if (bidx == BW'(DATA_W)) begin
            if (PARITY_EN != 0) begin
              txd_n   = par;
              state_n = PARITY;
            end else begin
              txd_n   = 1'b1;
              scnt_n  = 1'b0;
              state_n = STOP;
            end
          end else begin
            txd_n  = sh[0];
            sh_n   = sh >> 1;
            bidx_n = bidx + BW'(1);
          end
        end
        PARITY: begin
          txd_n   = 1'b1;
          scnt_n  = 1'b0;
          state_n = STOP;
        end
        STOP: begin
          if (scnt == 1'(STOP_BITS-1)) begin
            pop = !empty;
            if (empty) begin
              txd_n   = 1'b1;
              state_n = IDLE;
            end
          end else begin
            scnt_n = 1'b1;
          end
        end
        default: begin
          txd_n   = 1'b1;
          state_n = IDLE;
        end
      endcase
      if (pop) begin
        sh_n    = mem[rd_ptr];
        par_n   = (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
        txd_n   = 1'b0;
        state_n = START;
      end
    end
  end

endmodule

// File: tb/tb_spart_tx_fifo.sv
// tb_spart_tx_fifo: directed bench with per-DUT expected-bit scoreboards.
// Three configurations share clock, reset and baud tick.
module tb_spart_tx_fifo;

  typedef logic [1:0] ent_q [$];

  logic clk = 1'b0;
  logic rst;
  logic tx_enable;
  logic txd0, txd1, txd2;
  logic busy0, busy1, busy2;

  int checks   = 0;
  int failures = 0;

  ent_q q0, q1, q2;
  int   cnt0;
  logic ovf0;

  always #5 clk = ~clk;

  spart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus0 ();
  spart_tx_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus1 ();
  spart_tx_fifo_if #(.DATA_W(5), .FIFO_DEPTH(4)) bus2 ();

  spart_tx_fifo #(
    .DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable),
    .bus(bus0.slave), .txd(txd0), .tx_busy(busy0)
  );

  spart_tx_fifo #(
    .DATA_W(8), .FIFO_DEPTH(4), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable),
    .bus(bus1.slave), .txd(txd1), .tx_busy(busy1)
  );

  spart_tx_fifo #(
    .DATA_W(5), .FIFO_DEPTH(4), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable),
    .bus(bus2.slave), .txd(txd2), .tx_busy(busy2)
  );

  // entry = {start_flag, line_bit}
  function automatic ent_q frame(
    int w, int pe, int odd, int sb, logic [8:0] v
  );
    ent_q f;
    logic p;
    p = (odd != 0);
    f.push_back(2'b10);
    for (int i = 0; i < w; i++) begin
      f.push_back({1'b0, v[i]});
      p = p ^ v[i];
    end
    if (pe != 0)
      f.push_back({1'b0, p});
    for (int i = 0; i < sb; i++)
      f.push_back(2'b01);
    return f;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [2:0] sel, logic [8:0] v);
    @(negedge clk);
    bus0.write = sel[0];
    bus0.tx_in = v[7:0];
    bus1.write = sel[1];
    bus1.tx_in = v[7:0];
    bus2.write = sel[2];
    bus2.tx_in = v[4:0];
    @(posedge clk);
    #1;
    bus0.write = 1'b0;
    bus1.write = 1'b0;
    bus2.write = 1'b0;
    if (sel[0]) begin
      if (cnt0 < 4) begin
        cnt0++;
        q0 = {q0, frame(8, 0, 0, 1, v)};
      end else begin
        ovf0 = 1'b1;
      end
    end
    if (sel[1])
      q1 = {q1, frame(8, 1, 1, 2, v)};
    if (sel[2])
      q2 = {q2, frame(5, 1, 0, 1, v)};
  endtask

  task automatic tick(int gap);
    logic [1:0] e;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    tx_enable = 1'b1;
    @(posedge clk);
    #1;
    tx_enable = 1'b0;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      if (e[1])
        cnt0--;
      chk("txd0", 32'(txd0), 32'(e[0]));
      chk("busy0", 32'(busy0), 32'd1);
    end else begin
      chk("txd0_idle", 32'(txd0), 32'd1);
      chk("busy0_idle", 32'(busy0), 32'd0);
    end
    chk("count0", 32'(bus0.fifo_count), 32'(cnt0));
    chk("tbr0", 32'(bus0.tbr), 32'(cnt0 != 4));
    chk("ovf0", 32'(bus0.overflow), 32'(ovf0));
    if (q1.size() != 0) begin
      e = q1.pop_front();
      chk("txd1", 32'(txd1), 32'(e[0]));
      chk("busy1", 32'(busy1), 32'd1);
    end else begin
      chk("txd1_idle", 32'(txd1), 32'd1);
      chk("busy1_idle", 32'(busy1), 32'd0);
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk("txd2", 32'(txd2), 32'(e[0]));
      chk("busy2", 32'(busy2), 32'd1);
    end else begin
      chk("txd2_idle", 32'(txd2), 32'd1);
      chk("busy2_idle", 32'(busy2), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    tx_enable  = 1'b0;
    bus0.write = 1'b0;
    bus0.tx_in = '0;
    bus1.write = 1'b0;
    bus1.tx_in = '0;
    bus2.write = 1'b0;
    bus2.tx_in = '0;
    cnt0       = 0;
    ovf0       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_tbr", 32'(bus0.tbr), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", 32'(bus0.fifo_count), 32'd0);
    chk("rst_ovf", 32'(bus0.overflow), 32'd0);
    chk("rst_txd1", 32'(txd1), 32'd1);
    chk("rst_txd2", 32'(txd2), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // single frames on all three configurations, tick every 16 clk
    wr(3'b001, 9'h0A5);
    wr(3'b010, 9'h007);
    wr(3'b100, 9'h01B);
    repeat (13) tick(15);

    // three back-to-back words, contiguous frames
    wr(3'b001, 9'h001);
    wr(3'b001, 9'h002);
    wr(3'b001, 9'h003);
    chk("b2b_count", 32'(bus0.fifo_count), 32'd3);
    repeat (32) tick(3);

    // fill past full with ticks held low
    for (int i = 0; i < 6; i++) begin
      wr(3'b001, 9'(8'h30 + i));
      if (i == 3) begin
        chk("full_tbr", 32'(bus0.tbr), 32'd0);
        chk("full_count", 32'(bus0.fifo_count), 32'd4);
      end
    end
    chk("ovf_set", 32'(bus0.overflow), 32'd1);
    chk("ovf_count", 32'(bus0.fifo_count), 32'd4);
    repeat (42) tick(0);

    // reset mid-data with two words still queued
    wr(3'b001, 9'h055);
    wr(3'b001, 9'h0AA);
    wr(3'b001, 9'h0F0);
    repeat (3) tick(1);
    chk("pre_rst_count", 32'(bus0.fifo_count), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    cnt0 = 0;
    ovf0 = 1'b0;
    chk("mid_rst_txd", 32'(txd0), 32'd1);
    chk("mid_rst_count", 32'(bus0.fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ovf", 32'(bus0.overflow), 32'd0);
    chk("mid_rst_tbr", 32'(bus0.tbr), 32'd1);
    repeat (12) tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
